keypad_scanner: RTL and testbench



---
 rtl/keypad_scanner.sv | 217 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 active-low matrix keypad. Each column is strobed for SCAN_DIV
// cycles and the synchronized rows are sampled on the last cycle of that
// strobe. Full-scan results are debounced over DEBOUNCE_SCANS scans. Each
// accepted key is shifted into a 16-bit entry register.
//
// Ports
//   clk        system clock
//   rst_n      synchronous active-low reset
//   rows[3:0]  keypad row lines, active-low, asynchronous
//   clear      zeroes value on the next edge; wins over a coincident accept
//   cols[3:0]  column strobes, active-low, exactly one low
//   key_valid  one-cycle pulse per accepted key
//   key_code   last accepted code (4*row + col)
//   pressed    high while the accepted key is still considered held
//   value      entry register, newest digit in [3:0]
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | no key; waiting for a single-key scan
// S_DEBOUNCE | cand seen in cnt consecutive scans; not yet accepted
// S_HELD     | key accepted; cnt counts consecutive key-free scans
module keypad_scanner #(
  parameter int SCAN_DIV       = 2048,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  rows,
  input  logic        clear,
  output logic [3:0]  cols,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        pressed,
  output logic [15:0] value
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DIV_TC = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_HELD} state_e;

  logic [3:0]    rows_m_q, rows_s_q;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    col_q, col_d;
  logic [3:0]    cols_q;
  logic [1:0]    acc_hits_q;
  logic [3:0]    acc_code_q;
  state_e        state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          key_valid_q;
  logic [3:0]    key_code_q;
  logic          pressed_q;
  logic [15:0]   value_q;

  logic          sample, scan_done, res_key, accept;
  logic [2:0]    col_hits, hit_sum;
  logic [1:0]    col_row, tot_hits;
  logic [3:0]    first_code;

  assign sample = (div_q == DIV_TC);
  assign div_d  = sample ? '0 : div_q + 1'b1;
  assign col_d  = sample ? col_q + 2'd1 : col_q;

  // Hits in the active column; the loop runs downward so the lowest low row
  // wins. Which row is reported only matters when there is exactly one hit.
  always_comb begin
    col_hits = '0;
    col_row  = '0;
    for (int r = 3; r >= 0; r--) begin
      if (!rows_s_q[r]) begin
        col_hits = col_hits + 3'd1;
        col_row  = 2'(r);
      end
    end
  end

  assign hit_sum    = {1'b0, acc_hits_q} + col_hits;
  assign tot_hits   = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
  assign first_code = (acc_hits_q == 2'd0) ? {col_row, col_q} : acc_code_q;
  assign scan_done  = sample && (col_q == 2'd3);
  assign res_key    = scan_done && (tot_hits == 2'd1);
  assign cnt_inc    = cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rows_m_q   <= 4'hF;
      rows_s_q   <= 4'hF;
      div_q      <= '0;
      col_q      <= '0;
      cols_q     <= 4'b1110;
      acc_hits_q <= '0;
      acc_code_q <= '0;
    end else begin
      rows_m_q <= rows;
      rows_s_q <= rows_m_q;
      div_q    <= div_d;
      col_q    <= col_d;
      // Built from the next column so the strobe lines up with col_q.
      cols_q   <= ~(4'b0001 << col_d);
      if (sample) begin
        if (col_q == 2'd3) begin
          acc_hits_q <= '0;
          acc_code_q <= '0;
        end else begin
          acc_hits_q <= tot_hits;
          acc_code_q <= first_code;
        end
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state; a MULTI result counts the same as NONE everywhere.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    if (scan_done) begin
      unique case (state_q)
        S_IDLE: begin
          if (res_key) begin
            cand_d = first_code;
            if (DEBOUNCE_SCANS == 1) begin
              state_d = S_HELD;
              cnt_d   = '0;
            end else begin
              state_d = S_DEBOUNCE;
              cnt_d   = CW'(1);
            end
          end
        end
        S_DEBOUNCE: begin
          if (res_key && (first_code == cand_q)) begin
            if (cnt_inc == CNT_TC) begin
              state_d = S_HELD;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else if (res_key) begin
            cand_d = first_code;
            cnt_d  = CW'(1);
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
        S_HELD: begin
          if (res_key) begin
            cnt_d = '0;
          end else if (cnt_inc == CNT_TC) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // FSM outputs: the accept strobe
  always_comb begin
    accept = 1'b0;
    if (res_key) begin
      if (state_q == S_IDLE)
        accept = (DEBOUNCE_SCANS == 1);
      else if (state_q == S_DEBOUNCE)
        accept = (first_code == cand_q) && (cnt_inc == CNT_TC);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      pressed_q   <= 1'b0;
      value_q     <= '0;
    end else begin
      key_valid_q <= accept;
      pressed_q   <= (state_d == S_HELD);
      if (accept)
        key_code_q <= first_code;
      if (clear)
        value_q <= '0;
      else if (accept)
        value_q <= {value_q[11:0], first_code};
    end
  end

  assign cols      = cols_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign pressed   = pressed_q;
  assign value     = value_q;

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int D  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  rows;
  logic        clear = 1'b0;
  logic [3:0]  cols;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        pressed;
  logic [15:0] value;

  logic [15:0] keys = '0;

  int checks = 0;
  int errors = 0;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(D)) dut (
    .clk(clk), .rst_n(rst_n), .rows(rows), .clear(clear),
    .cols(cols), .key_valid(key_valid), .key_code(key_code),
    .pressed(pressed), .value(value)
  );

  always #5 clk = ~clk;

  // Physical keypad: key 4r+c pulls row r low while column c is strobed.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!cols[c] && keys[4*r+c]) rows[r] = 1'b0;
  end

  // Reference model: a sliding window of the last D scan results.
  int          hist[$];
  bit          m_valid, m_held;
  logic [3:0]  m_code;
  logic [15:0] m_value;

  function automatic void model_reset();
    hist.delete();
    m_valid = 0; m_held = 0; m_code = '0; m_value = '0;
  endfunction

  function automatic void model_step(input logic [15:0] mask, input bit clr);
    int  res;
    bit  all_key, all_none;
    res = -1;
    if ($countones(mask) == 1)
      for (int i = 0; i < 16; i++) if (mask[i]) res = i;
    hist.push_back(res);
    if (hist.size() > D) void'(hist.pop_front());
    m_valid = 0;
    if (hist.size() == D) begin
      all_key  = (res >= 0);
      all_none = 1;
      foreach (hist[i]) begin
        if (hist[i] != res) all_key = 0;
        if (hist[i] >= 0) all_none = 0;
      end
      if (!m_held && all_key) begin
        m_valid = 1;
        m_code  = res[3:0];
        m_held  = 1;
        m_value = {m_value[11:0], res[3:0]};
      end else if (m_held && all_none) begin
        m_held = 0;
      end
    end
    if (clr) m_value = '0;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Entered at posedge+1 of cycle 0 of a scan; leaves at the same point of
  // the next scan, one cycle after this scan's result.
  task automatic run_scan(input logic [15:0] mask, input bit clr);
    keys = mask;
    repeat (7) @(posedge clk);
    #1 chk("key_valid_mid_scan", {15'd0, key_valid}, 16'd0);
    repeat (8) @(posedge clk);
    #1 clear = clr;
    @(posedge clk);
    #1 clear = 1'b0;
    model_step(mask, clr);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      keys = 16'($urandom);
      @(posedge clk);
      #1;
    end
    chk("rst_cols", {12'd0, cols}, 16'h000E);
    chk("rst_key_valid", {15'd0, key_valid}, 16'd0);
    chk("rst_key_code", {12'd0, key_code}, 16'd0);
    chk("rst_pressed", {15'd0, pressed}, 16'd0);
    chk("rst_value", value, 16'd0);
    keys  = '0;
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [15:0] mask;
    bit          clr;
    bit          v;
    logic [3:0]  code;
    bit          p;
    logic [15:0] val;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [15:0] mask, input bit clr, input bit v,
                              input logic [3:0] code, input bit p, input logic [15:0] val);
    vec_t e;
    e.mask = mask; e.clr = clr; e.v = v; e.code = code; e.p = p; e.val = val;
    vecs.push_back(e);
  endfunction

  // Two scans pressed, two released.
  function automatic void press_release(input int k, input logic [3:0] prev_code,
                                        input logic [15:0] prev_val, input logic [15:0] new_val);
    logic [15:0] m;
    m = 16'd1 << k;
    add(m, 0, 0, prev_code, 0, prev_val);
    add(m, 0, 1, 4'(k), 1, new_val);
    add('0, 0, 0, 4'(k), 1, new_val);
    add('0, 0, 0, 4'(k), 0, new_val);
  endfunction

  task automatic check_outputs(input string tag, input bit v, input logic [3:0] code,
                               input bit p, input logic [15:0] val);
    chk({tag, "_key_valid"}, {15'd0, key_valid}, {15'd0, v});
    chk({tag, "_key_code"}, {12'd0, key_code}, {12'd0, code});
    chk({tag, "_pressed"}, {15'd0, pressed}, {15'd0, p});
    chk({tag, "_value"}, value, val);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  one;
    logic [15:0] m;
    int          r;
    bit          c;

    press_release(9, 4'h0, 16'h0000, 16'h0009);
    add('0, 1, 0, 4'h9, 0, 16'h0000);
    press_release(1, 4'h9, 16'h0000, 16'h0001);
    press_release(2, 4'h1, 16'h0001, 16'h0012);
    press_release(3, 4'h2, 16'h0012, 16'h0123);
    press_release(4, 4'h3, 16'h0123, 16'h1234);
    press_release(5, 4'h4, 16'h1234, 16'h2345);
    add(16'h0400, 0, 0, 4'h5, 0, 16'h2345);
    add(16'h0000, 0, 0, 4'h5, 0, 16'h2345);
    add(16'h0400, 0, 0, 4'h5, 0, 16'h2345);
    add(16'h0400, 0, 1, 4'hA, 1, 16'h345A);
    add(16'h0000, 0, 0, 4'hA, 1, 16'h345A);
    add(16'h0000, 0, 0, 4'hA, 0, 16'h345A);
    repeat (3) add(16'h0021, 0, 0, 4'hA, 0, 16'h345A);
    add(16'h0008, 0, 0, 4'hA, 0, 16'h345A);
    add(16'h0008, 0, 1, 4'h3, 1, 16'h45A3);
    add(16'h0088, 0, 0, 4'h3, 1, 16'h45A3);
    add(16'h0080, 0, 0, 4'h3, 1, 16'h45A3);
    add(16'h0080, 0, 0, 4'h3, 1, 16'h45A3);
    add(16'h0000, 0, 0, 4'h3, 1, 16'h45A3);
    add(16'h0000, 0, 0, 4'h3, 0, 16'h45A3);
    add(16'h0000, 1, 0, 4'h3, 0, 16'h0000);
    press_release(10, 4'h3, 16'h0000, 16'h000A);
    add(16'h0800, 0, 0, 4'hA, 0, 16'h000A);
    add(16'h0800, 0, 1, 4'hB, 1, 16'h00AB);
    add(16'h0800, 1, 0, 4'hB, 1, 16'h0000);
    add(16'h0000, 0, 0, 4'hB, 1, 16'h0000);
    add(16'h0000, 0, 0, 4'hB, 0, 16'h0000);
    press_release(1, 4'hB, 16'h0000, 16'h0001);
    add(16'h0040, 0, 0, 4'h1, 0, 16'h0001);
    add(16'h0040, 1, 1, 4'h6, 1, 16'h0000);
    add(16'h0000, 0, 0, 4'h6, 1, 16'h0000);
    add(16'h0000, 0, 0, 4'h6, 0, 16'h0000);

    // Reset with rows toggling, then column stepping through scan 0.
    @(posedge clk);
    #1 do_reset(3);
    one = 4'b0001;
    for (int i = 0; i < 16; i++) begin
      chk("cols_step", {12'd0, cols}, {12'd0, ~(one << (i / 4))});
      @(posedge clk);
      #1;
    end
    model_step('0, 0);
    check_outputs("scan0", 0, 4'h0, 0, 16'h0000);

    foreach (vecs[i]) begin
      run_scan(vecs[i].mask, vecs[i].clr);
      check_outputs("vec", vecs[i].v, vecs[i].code, vecs[i].p, vecs[i].val);
    end

    for (int n = 0; n < 160; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 35)
        m = '0;
      else if (r < 80)
        m = 16'd1 << $urandom_range(0, 15);
      else begin
        m = 16'd1 << $urandom_range(0, 15);
        while ($countones(m) < 2) m = m | (16'd1 << $urandom_range(0, 15));
      end
      c = ($urandom_range(0, 9) == 0);
      run_scan(m, c);
      check_outputs("rand", m_valid, m_code, m_held, m_value);
    end

    // Reset in the middle of a debounce: the count must restart from zero.
    run_scan(16'h0004, 0);
    keys = 16'h0004;
    repeat (5) @(posedge clk);
    #1 do_reset(2);
    run_scan(16'h0004, 0);
    check_outputs("post_rst1", 0, 4'h0, 0, 16'h0000);
    run_scan(16'h0004, 0);
    check_outputs("post_rst2", 1, 4'h2, 1, 16'h0002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
